uart_tx_io: RTL and testbench

Memory-mapped UART transmitter that sits directly downstream of the core's IO port in the SOC. It consumes the core's IO write strobe and address and data, queues bytes in a small FIFO, and serialises them 8N1 on `tx`. It returns a side-effect-free status word on the IO read data bus, which the core samples in its memory stage.

---
 rtl/uart_tx_io_pkg.sv | 22 ++
 rtl/uart_fifo.sv | 58 +++++
 rtl/uart_tx_io.sv | 159 +++++++++++++++
 tb/tb_uart_tx_io.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_io_pkg.sv
// rtl/uart_tx_io_pkg.sv - shared UART decode constants, status bit positions and TX state encoding
package uart_tx_io_pkg;

  localparam int SEL_BIT  = 3;
  localparam int CTRL_BIT = 31;

  localparam int ST_OVF  = 10;
  localparam int ST_BUSY = 9;
  localparam int ST_FULL = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  function automatic int clocks_per_bit(input int clk_freq_hz, input int baud);
    return clk_freq_hz / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with first-word-fall-through read data
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_io.sv
// rtl/uart_tx_io.sv - memory-mapped 8N1 UART transmitter; UART_TX_ECHO_EN echoes accepted bytes to the sim console
module uart_tx_io
  import uart_tx_io_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_wr,
  output logic [31:0] io_rdata,
  output logic        tx,
  output logic        busy
);

  localparam int DIV = clocks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] DIV_M1 = BW'(DIV - 1);

  logic          sel;
  logic          wr_data;
  logic          wr_ctrl;
  logic          pop;
  logic          full;
  logic          empty;
  logic [7:0]    dout;
  logic [CW-1:0] count;
  logic          ovf;
  logic          bit_end;
  tx_state_t     state;
  logic [BW-1:0] baud;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic          unused_bits;

  assign sel     = io_addr[SEL_BIT];
  assign wr_data = io_wr & sel & ~io_wdata[CTRL_BIT];
  assign wr_ctrl = io_wr & sel & io_wdata[CTRL_BIT];
  assign bit_end = (baud == '0);
  // Pop from IDLE, or at the very end of a stop bit so the next start bit is contiguous.
  assign pop     = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));
  assign busy    = (state != IDLE) | (count != '0);
  assign unused_bits = ^{io_addr[31:SEL_BIT+1], io_addr[SEL_BIT-1:0], io_wdata[CTRL_BIT-1:8]};

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (wr_data),
    .pop    (pop),
    .din    (io_wdata[7:0]),
    .dout   (dout),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    io_rdata = '0;
    if (sel) begin
      io_rdata[ST_OVF]  = ovf;
      io_rdata[ST_BUSY] = busy;
      io_rdata[ST_FULL] = full;
      io_rdata[7:0]     = 8'(count);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovf <= 1'b0;
    end else if (wr_ctrl) begin
      ovf <= 1'b0;
    end else if (wr_data & full & ~pop) begin
      ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      tx    <= 1'b1;
      baud  <= '0;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            shreg <= dout;
            baud  <= DIV_M1;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud  <= DIV_M1;
            bitn  <= '0;
            tx    <= shreg[0];
            state <= DATA;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud  <= DIV_M1;
            shreg <= {1'b0, shreg[7:1]};
            if (bitn == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bitn <= bitn + 1'b1;
              tx   <= shreg[1];
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!empty) begin
              shreg <= dout;
              baud  <= DIV_M1;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_ECHO_EN
  logic push_ok;
  assign push_ok = wr_data & (~full | pop);

  always_ff @(posedge clk) begin
    if (resetn && push_ok) begin
      $write("%c", io_wdata[7:0]);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_io.sv
// tb/tb_uart_tx_io.sv - randomized self-checking bench for uart_tx_io against a frame-level line model
module tb_uart_tx_io;

  localparam int CLK_HZ  = 16;
  localparam int BAUD_R  = 4;
  localparam int DEPTH   = 4;
  localparam int DIVN    = CLK_HZ / BAUD_R;
  localparam int FRAME   = 10 * DIVN;
  localparam logic [31:0] UART_A  = 32'h0040_0008;
  localparam logic [31:0] OTHER_A = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] io_addr = '0;
  logic [31:0] io_wdata = '0;
  logic        io_wr = 1'b0;
  logic [31:0] io_rdata;
  logic        tx;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  uart_tx_io #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD        (BAUD_R),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_wr    (io_wr),
    .io_rdata (io_rdata),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_addr  = a;
    io_wdata = d;
    io_wr    = 1'b1;
    step();
    io_wr    = 1'b0;
    io_addr  = UART_A;
  endtask

  task automatic do_reset();
    io_wr   = 1'b0;
    io_addr = UART_A;
    resetn  = 1'b0;
    step();
    step();
    resetn  = 1'b1;
  endtask

  // 8N1 line level for bit slot j of a frame carrying b: start, eight data LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  // k counts clocks from the first start-bit clock of exp_q[0]; negative k is pre-start idle.
  task automatic run_frames(input int k0);
    int total;
    logic e;
    total = exp_q.size() * FRAME;
    for (int k = k0; k < total; k++) begin
      e = (k < 0) ? 1'b1 : frame_bit(exp_q[k / FRAME], (k % FRAME) / DIVN);
      tests++;
      if (tx !== e) begin
        fails++;
        $display("FAIL line k=%0d: tx=%b expected %b", k, tx, e);
      end
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL busy_during k=%0d: busy=%b expected 1", k, busy);
      end
      step();
    end
    tests++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      fails++;
      $display("FAIL drained: busy=%b tx=%b expected busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (io_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_status: io_rdata=0x%0h expected 0x0", io_rdata);
    end
    tests++;
    if (tx !== 1'b1) begin
      fails++;
      $display("FAIL reset_tx: tx=%b expected 1", tx);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    exp_q = {8'h55};
    wr(UART_A, 32'h55);
    tests++;
    if (io_rdata !== 32'h201) begin
      fails++;
      $display("FAIL single_status: io_rdata=0x%0h expected 0x201", io_rdata);
    end
    run_frames(-1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q = {8'h41, 8'h42};
    wr(UART_A, 32'h41);
    wr(UART_A, 32'h42);
    run_frames(0);
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    do_reset();
    exp_q = {};
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      if (i < 5) exp_q.push_back(b);
      wr(UART_A, {24'h0, b});
    end
    tests++;
    if (io_rdata !== 32'h704) begin
      fails++;
      $display("FAIL ovf_status: io_rdata=0x%0h expected 0x704", io_rdata);
    end
    wr(UART_A, 32'h8000_0000);
    tests++;
    if (io_rdata !== 32'h304) begin
      fails++;
      $display("FAIL ovf_clear: io_rdata=0x%0h expected 0x304", io_rdata);
    end
    run_frames(5);
  endtask

  task automatic test_full_pop();
    logic [7:0] b [6];
    do_reset();
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) wr(UART_A, {24'h0, b[i]});
    repeat (FRAME - 4) step();
    tests++;
    if (io_rdata !== 32'h304 || tx !== 1'b1) begin
      fails++;
      $display("FAIL full_before: io_rdata=0x%0h tx=%b expected 0x304 tx=1", io_rdata, tx);
    end
    wr(UART_A, {24'h0, b[5]});
    tests++;
    if (io_rdata !== 32'h304) begin
      fails++;
      $display("FAIL full_pop_status: io_rdata=0x%0h expected 0x304", io_rdata);
    end
    exp_q = {b[1], b[2], b[3], b[4], b[5]};
    run_frames(0);
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    wr(UART_A, 32'hA5);
    wr(UART_A, 32'h3C);
    repeat (4 * DIVN + 1) step();
    resetn = 1'b0;
    step();
    tests++;
    if (tx !== 1'b1 || io_rdata !== 32'h0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: tx=%b io_rdata=0x%0h busy=%b expected 1/0x0/0", tx, io_rdata, busy);
    end
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL after_reset_quiet: %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_random();
    int n;
    int f;
    logic [7:0] b;
    logic hit;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(0, 5)) step();
      n = $urandom_range(1, 5);
      f = -1;
      exp_q = {};
      for (int i = 0; i < n; i++) begin
        b   = 8'($urandom);
        hit = ($urandom_range(0, 3) != 0);
        if (hit) begin
          if (f < 0) f = i;
          exp_q.push_back(b);
          wr(UART_A, {24'h0, b});
        end else begin
          wr(OTHER_A, {$urandom_range(0, 1) == 1, 23'h0, b});
        end
      end
      if (f >= 0) begin
        run_frames(n - 2 - f);
      end else begin
        step();
        tests++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
          fails++;
          $display("FAIL unselected_ignored: busy=%b tx=%b expected 0/1", busy, tx);
        end
      end
      tests++;
      if (io_rdata !== 32'h0) begin
        fails++;
        $display("FAIL random_idle_status it=%0d: io_rdata=0x%0h expected 0x0", it, io_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
